// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  localparam int STATE_W           = 2;
  localparam int REG_ADDRWIDTH_DEF = 5;

  typedef enum logic [STATE_W-1:0] {
    PC_RUN     = 2'd0,
    PC_MEMWAIT = 2'd1,
    PC_REDIR   = 2'd2
  } pc_state_e;

  // Width needed to hold a wait count up to and including the timeout value.
  function automatic int wait_w(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard status from the pipeline stages and the stage-register controls returned to them.
// Latency: wires only.
// Backpressure: carried in-band as per-stage write enables and flushes.
interface pipe_ctrl_if import pipe_ctrl_pkg::*; #(
  parameter int REG_ADDRWIDTH = REG_ADDRWIDTH_DEF,
  parameter int CNT_W         = 32
);

  logic                     id_valid;
  logic [REG_ADDRWIDTH-1:0] id_rs1_idx;
  logic                     id_rs1_ren;
  logic [REG_ADDRWIDTH-1:0] id_rs2_idx;
  logic                     id_rs2_ren;
  logic                     ex_valid;
  logic [REG_ADDRWIDTH-1:0] ex_rd_idx;
  logic                     ex_rd_wen;
  logic                     ex_is_load;
  logic                     ex_redirect;
  logic                     trap_req;
  logic                     mem_busy;

  logic                     pc_wen;
  logic                     if_id_wen;
  logic                     id_ex_wen;
  logic                     ex_mem_wen;
  logic                     mem_wb_wen;
  logic                     if_id_flush;
  logic                     id_ex_flush;
  logic                     ex_mem_flush;
  logic                     mem_wb_flush;
  logic [STATE_W-1:0]       state;
  logic [CNT_W-1:0]         stall_cnt;
  logic                     mem_timeout;

  // Pipeline side: reports hazards, consumes controls.
  modport master (
    output id_valid, id_rs1_idx, id_rs1_ren, id_rs2_idx, id_rs2_ren,
    output ex_valid, ex_rd_idx, ex_rd_wen, ex_is_load, ex_redirect,
    output trap_req, mem_busy,
    input  pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen,
    input  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
    input  state, stall_cnt, mem_timeout
  );

  // Controller side: consumes hazards, drives controls.
  modport slave (
    input  id_valid, id_rs1_idx, id_rs1_ren, id_rs2_idx, id_rs2_ren,
    input  ex_valid, ex_rd_idx, ex_rd_wen, ex_is_load, ex_redirect,
    input  trap_req, mem_busy,
    output pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen,
    output if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
    output state, stall_cnt, mem_timeout
  );

endinterface

// File: rtl/pipe_ctrl_hazard.sv
// Load-use detector: a load in EX whose rd is a source of the instruction in ID.
// Latency: purely combinational.
// Backpressure: none; the caller turns the flag into a stall.
module hazard_detect import pipe_ctrl_pkg::*; #(
  parameter int REG_ADDRWIDTH = REG_ADDRWIDTH_DEF
) (
  input  logic                     i_id_valid,
  input  logic [REG_ADDRWIDTH-1:0] i_id_rs1_idx,
  input  logic                     i_id_rs1_ren,
  input  logic [REG_ADDRWIDTH-1:0] i_id_rs2_idx,
  input  logic                     i_id_rs2_ren,
  input  logic                     i_ex_valid,
  input  logic [REG_ADDRWIDTH-1:0] i_ex_rd_idx,
  input  logic                     i_ex_rd_wen,
  input  logic                     i_ex_is_load,
  output logic                     o_load_use
);

  logic w_ex_load_wr;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is hardwired, so a load targeting it never creates a dependency.
  assign w_ex_load_wr = i_ex_valid & i_ex_is_load & i_ex_rd_wen & (i_ex_rd_idx != '0);
  assign w_rs1_hit    = i_id_rs1_ren & (i_id_rs1_idx == i_ex_rd_idx);
  assign w_rs2_hit    = i_id_rs2_ren & (i_id_rs2_idx == i_ex_rd_idx);
  assign o_load_use   = i_id_valid & w_ex_load_wr & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the five-stage pipeline: PC and four stage registers.
// Latency: controls are combinational from state and inputs; state and counters update next edge.
// Backpressure: holds the front end via write enables on LSU waits and load-use; never stalled itself.
module pipe_ctrl import pipe_ctrl_pkg::*; #(
  parameter int REG_ADDRWIDTH = REG_ADDRWIDTH_DEF,
  parameter int MEM_TIMEOUT   = 255,
  parameter int CNT_W         = 32
) (
  input  logic      clk,
  input  logic      rst,
  pipe_ctrl_if.slave bus
);

  localparam int                WAIT_W      = wait_w(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

  pc_state_e         r_state;
  pc_state_e         w_state_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              r_mem_timeout;
  logic              w_load_use;
  logic              w_hold;
  logic              w_pc_wen;
  logic              w_if_id_wen;
  logic              w_id_ex_wen;
  logic              w_ex_mem_wen;
  logic              w_mem_wb_wen;
  logic              w_if_id_flush;
  logic              w_id_ex_flush;
  logic              w_ex_mem_flush;
  logic              w_mem_wb_flush;

  hazard_detect #(.REG_ADDRWIDTH(REG_ADDRWIDTH)) u_hazard (
    .i_id_valid   (bus.id_valid),
    .i_id_rs1_idx (bus.id_rs1_idx),
    .i_id_rs1_ren (bus.id_rs1_ren),
    .i_id_rs2_idx (bus.id_rs2_idx),
    .i_id_rs2_ren (bus.id_rs2_ren),
    .i_ex_valid   (bus.ex_valid),
    .i_ex_rd_idx  (bus.ex_rd_idx),
    .i_ex_rd_wen  (bus.ex_rd_wen),
    .i_ex_is_load (bus.ex_is_load),
    .o_load_use   (w_load_use)
  );

  // Pick the highest-priority event this cycle and derive every stage control from it.
  always_comb begin
    w_pc_wen       = 1'b1;
    w_if_id_wen    = 1'b1;
    w_id_ex_wen    = 1'b1;
    w_ex_mem_wen   = 1'b1;
    w_mem_wb_wen   = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_flush = 1'b0;
    w_mem_wb_flush = 1'b0;
    w_state_nxt    = PC_RUN;
    w_hold         = 1'b0;
    if (!rst) begin
      w_pc_wen       = 1'b0;
      w_if_id_wen    = 1'b0;
      w_id_ex_wen    = 1'b0;
      w_ex_mem_wen   = 1'b0;
      w_mem_wb_wen   = 1'b0;
      w_if_id_flush  = 1'b1;
      w_id_ex_flush  = 1'b1;
      w_ex_mem_flush = 1'b1;
      w_mem_wb_flush = 1'b1;
    end else begin
      if (bus.trap_req) begin
        // Trap commits from MEM: everything younger is discarded, MEM result retires.
        w_if_id_flush  = 1'b1;
        w_id_ex_flush  = 1'b1;
        w_ex_mem_flush = 1'b1;
        w_state_nxt    = PC_REDIR;
      end else if (bus.mem_busy) begin
        w_pc_wen       = 1'b0;
        w_if_id_wen    = 1'b0;
        w_id_ex_wen    = 1'b0;
        w_ex_mem_wen   = 1'b0;
        w_mem_wb_flush = 1'b1;
        w_state_nxt    = PC_MEMWAIT;
        w_hold         = 1'b1;
      end else if (bus.ex_redirect) begin
        w_if_id_flush  = 1'b1;
        w_id_ex_flush  = 1'b1;
        w_state_nxt    = PC_REDIR;
      end else if (w_load_use) begin
        w_pc_wen       = 1'b0;
        w_if_id_wen    = 1'b0;
        w_id_ex_flush  = 1'b1;
      end
      // The I-memory's one-cycle latency leaves a wrong-path fetch in IF after a redirect.
      if (r_state == PC_REDIR) begin
        w_if_id_flush = 1'b1;
      end
    end
  end

  // Consecutive held cycles: continue counting in MEMWAIT, restart at one on entry.
  always_comb begin
    w_wait_nxt = WAIT_W'(1);
    if (r_state == PC_MEMWAIT) begin
      w_wait_nxt = (r_wait_cnt < TIMEOUT_VAL) ? r_wait_cnt + WAIT_W'(1) : r_wait_cnt;
    end
  end

  // FSM state, stall performance counter and sticky LSU timeout.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= PC_RUN;
      r_stall_cnt   <= '0;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (!w_pc_wen && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_hold) begin
        r_wait_cnt <= w_wait_nxt;
        if (w_wait_nxt == TIMEOUT_VAL) begin
          r_mem_timeout <= 1'b1;
        end
      end
    end
  end

  assign bus.pc_wen       = w_pc_wen;
  assign bus.if_id_wen    = w_if_id_wen;
  assign bus.id_ex_wen    = w_id_ex_wen;
  assign bus.ex_mem_wen   = w_ex_mem_wen;
  assign bus.mem_wb_wen   = w_mem_wb_wen;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.id_ex_flush  = w_id_ex_flush;
  assign bus.ex_mem_flush = w_ex_mem_flush;
  assign bus.mem_wb_flush = w_mem_wb_flush;
  assign bus.state        = r_state;
  assign bus.stall_cnt    = r_stall_cnt;
  assign bus.mem_timeout  = r_mem_timeout;

endmodule
